threshold_stage: RTL and testbench

//  Per-pixel RGB threshold engine; sits directly upstream of the BMP write stage.
//  - Consumes the two-pixel-per-cycle stream (even/odd RGB pairs, qualified by a horizontal pulse).
//  - Thresholds each pixel on its channel sum against a per-frame threshold.
//  - Emits the same pair format and pulse, 2 cycles later, plus an end-of-frame pulse.

---
 rtl/threshold_pkg.sv | 16 +
 rtl/threshold_stage_if.sv | 24 ++
 rtl/threshold_pixel.sv | 70 +++++++
 rtl/threshold_stage.sv | 110 +++++++++++
 tb/tb_threshold_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/threshold_pkg.sv
// Shared constants and helpers for the threshold stage.
// Ports: none (package). Provides the mode encodings, the sum width, the
// saturated pixel value and the 3*T limit helper.
package threshold_pkg;

  localparam logic       MODE_BINARY = 1'b0;
  localparam logic       MODE_TOZERO = 1'b1;
  localparam int         SUM_W       = 10;
  localparam logic [7:0] PIX_MAX     = 8'd255;

  // 3*T done as T + 2*T so it stays a plain adder.
  function automatic logic [SUM_W-1:0] triple(input logic [7:0] t);
    return {2'b00, t} + {1'b0, t, 1'b0};
  endfunction

endpackage

// File: rtl/threshold_stage_if.sv
// Two-pixel-per-cycle RGB pair bus qualified by a horizontal pulse.
// Ports: horizontal_Pulse (pair valid), data_{R,G,B}_{Even,Odd} (8-bit components).
// master drives the pair, slave receives it; there is no backpressure signal.
interface threshold_stage_if;
  logic       horizontal_Pulse;
  logic [7:0] data_R_Even;
  logic [7:0] data_G_Even;
  logic [7:0] data_B_Even;
  logic [7:0] data_R_Odd;
  logic [7:0] data_G_Odd;
  logic [7:0] data_B_Odd;

  modport master (
    output horizontal_Pulse,
    output data_R_Even, data_G_Even, data_B_Even,
    output data_R_Odd,  data_G_Odd,  data_B_Odd
  );

  modport slave (
    input horizontal_Pulse,
    input data_R_Even, data_G_Even, data_B_Even,
    input data_R_Odd,  data_G_Odd,  data_B_Odd
  );
endinterface

// File: rtl/threshold_pixel.sv
// One pixel's threshold datapath: S1 registers sum/limit/RGB/mode, S2 registers the result.
// Ports: clk, reset (async active-low), in_valid + RGB + frame T/mode in, s1_valid
// from the shared valid pipeline, thresholded RGB out (holds when no pair is emitted).
module threshold_pixel
  import threshold_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic [7:0] t_value,
  input  logic       mode,
  input  logic       s1_valid,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] lim_q;
  logic [7:0]       r_q, g_q, b_q;
  logic             mode_q;
  logic             over;

  // Strict compare: a sum exactly at the limit stays dark.
  assign over = (sum_q > lim_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q  <= '0;
      lim_q  <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_BINARY;
    end else if (in_valid) begin
      sum_q  <= SUM_W'(r_in) + SUM_W'(g_in) + SUM_W'(b_in);
      lim_q  <= triple(t_value);
      r_q    <= r_in;
      g_q    <= g_in;
      b_q    <= b_in;
      mode_q <= mode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
    end else if (s1_valid) begin
      if (!over) begin
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
      end else if (mode_q == MODE_TOZERO) begin
        r_out <= r_q;
        g_out <= g_q;
        b_out <= b_q;
      end else begin
        r_out <= PIX_MAX;
        g_out <= PIX_MAX;
        b_out <= PIX_MAX;
      end
    end
  end

endmodule

// File: rtl/threshold_stage.sv
// Per-pixel RGB threshold on even/odd pairs, 2-cycle latency, plus end-of-frame pulse.
// Ports: clk, reset (async active-low), in_bus (slave pair bus), threshold_Value/Mode
// (captured at frame start), out_bus (master pair bus), frame_Done. No backpressure.
module threshold_stage
  import threshold_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  threshold_stage_if.slave         in_bus,
  input  logic [7:0]               threshold_Value,
  input  logic                     threshold_Mode,
  threshold_stage_if.master        out_bus,
  output logic                     frame_Done
);

  localparam int PAIRS = IMAGE_WIDTH / 2;
  localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [7:0]       t_frame_q;
  logic             mode_frame_q;
  logic             s1_valid_q;
  logic             s1_last_q;

  logic             in_vld;
  logic             col_end;
  logic             row_end;
  logic             frame_start;
  logic [7:0]       t_use;
  logic             mode_use;

  assign in_vld      = in_bus.horizontal_Pulse;
  assign col_end     = (col_q == COL_W'(PAIRS - 1));
  assign row_end     = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  assign frame_start = in_vld && (col_q == '0) && (row_q == '0);

  // The first pair of a frame sees the freshly sampled parameters, not last frame's.
  assign t_use    = frame_start ? threshold_Value : t_frame_q;
  assign mode_use = frame_start ? threshold_Mode  : mode_frame_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      t_frame_q    <= '0;
      mode_frame_q <= MODE_BINARY;
    end else if (in_vld) begin
      if (frame_start) begin
        t_frame_q    <= threshold_Value;
        mode_frame_q <= threshold_Mode;
      end
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q               <= 1'b0;
      s1_last_q                <= 1'b0;
      out_bus.horizontal_Pulse <= 1'b0;
      frame_Done               <= 1'b0;
    end else begin
      s1_valid_q               <= in_vld;
      s1_last_q                <= in_vld && col_end && row_end;
      out_bus.horizontal_Pulse <= s1_valid_q;
      frame_Done               <= s1_valid_q && s1_last_q;
    end
  end

  threshold_pixel u_even (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_vld),
    .r_in     (in_bus.data_R_Even),
    .g_in     (in_bus.data_G_Even),
    .b_in     (in_bus.data_B_Even),
    .t_value  (t_use),
    .mode     (mode_use),
    .s1_valid (s1_valid_q),
    .r_out    (out_bus.data_R_Even),
    .g_out    (out_bus.data_G_Even),
    .b_out    (out_bus.data_B_Even)
  );

  threshold_pixel u_odd (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_vld),
    .r_in     (in_bus.data_R_Odd),
    .g_in     (in_bus.data_G_Odd),
    .b_in     (in_bus.data_B_Odd),
    .t_value  (t_use),
    .mode     (mode_use),
    .s1_valid (s1_valid_q),
    .r_out    (out_bus.data_R_Odd),
    .g_out    (out_bus.data_G_Odd),
    .b_out    (out_bus.data_B_Odd)
  );

endmodule

// File: tb/tb_threshold_stage.sv
// Bench for threshold_stage with a 4x2 frame so frame boundaries come quickly.
// Stimulus pushes hand-computed expected pairs; a negedge monitor pops and compares.
module tb_threshold_stage;

  typedef struct {
    int          cyc;
    logic [47:0] dat;   // {R,G,B even, R,G,B odd}
    logic        done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] threshold_Value = 8'd0;
  logic       threshold_Mode = 1'b0;
  logic       frame_Done;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  exp_t       sb[$];

  threshold_stage_if in_if ();
  threshold_stage_if out_if ();

  threshold_stage #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_bus          (in_if),
    .threshold_Value (threshold_Value),
    .threshold_Mode  (threshold_Mode),
    .out_bus         (out_if),
    .frame_Done      (frame_Done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] out_dat();
    return {out_if.data_R_Even, out_if.data_G_Even, out_if.data_B_Even,
            out_if.data_R_Odd,  out_if.data_G_Odd,  out_if.data_B_Odd};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_if.horizontal_Pulse) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL latency: output at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
        n_vec++;
        if (out_dat() !== e.dat) begin
          n_bad++;
          $display("FAIL pair_data: got %h, required %h (cycle %0d)", out_dat(), e.dat, cyc);
        end
        n_vec++;
        if (frame_Done !== e.done) begin
          n_bad++;
          $display("FAIL frame_done: got %b, required %b (cycle %0d)", frame_Done, e.done, cyc);
        end
      end
    end else if (frame_Done !== 1'b0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_without_pulse: frame_Done=%b, required 0 (cycle %0d)", frame_Done, cyc);
    end
  end

  task automatic set_pair(input logic p, input logic [47:0] d);
    in_if.horizontal_Pulse = p;
    {in_if.data_R_Even, in_if.data_G_Even, in_if.data_B_Even,
     in_if.data_R_Odd,  in_if.data_G_Odd,  in_if.data_B_Odd} = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_pair(1'b0, 48'h0);
    repeat (n) tick();
  endtask

  // Drive one pair for one cycle; expectation lands two cycles later.
  task automatic send(input logic [47:0] d, input logic [7:0] t, input logic m,
                      input logic [47:0] exp_d, input logic exp_done, input bit expect_out);
    exp_t e;
    threshold_Value = t;
    threshold_Mode  = m;
    set_pair(1'b1, d);
    if (expect_out) begin
      e.cyc  = cyc + 2;
      e.dat  = exp_d;
      e.done = exp_done;
      sb.push_back(e);
    end
    tick();
    set_pair(1'b0, 48'h0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_pair(1'($urandom_range(0, 1)), {$urandom, $urandom_range(0, 65535)});
      threshold_Value = 8'($urandom);
      threshold_Mode  = 1'($urandom_range(0, 1));
      #3;
      n_vec++;
      if ({out_dat(), out_if.horizontal_Pulse, frame_Done} !== 50'h0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %h/%b/%b, required all 0",
                 out_dat(), out_if.horizontal_Pulse, frame_Done);
      end
      tick();
    end
    set_pair(1'b0, 48'h0);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    set_pair(1'b0, 48'h0);
    #1;
    // 1: reset with random inputs
    do_reset(6);

    // 2: binary T=128, equality boundary on odd
    send({8'd130, 8'd130, 8'd130, 8'd128, 8'd128, 8'd128}, 8'd128, 1'b0,
         {24'hFFFFFF, 24'h000000}, 1'b0, 1'b1);
    idle(4);

    // 3: to-zero T=100
    do_reset(2);
    send({8'd200, 8'd50, 8'd60, 8'd100, 8'd100, 8'd99}, 8'd100, 1'b1,
         {8'd200, 8'd50, 8'd60, 24'h000000}, 1'b0, 1'b1);
    idle(4);

    // 4: T captured at frame start only, gaps between pairs (lim 30)
    do_reset(2);
    send({8'd10, 8'd10, 8'd11, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b0,
         {24'hFFFFFF, 24'h000000}, 1'b0, 1'b1);
    idle(2);
    send({8'd10, 8'd10, 8'd11, 8'd0, 8'd0, 8'd31}, 8'd200, 1'b0,
         {24'hFFFFFF, 24'hFFFFFF}, 1'b0, 1'b1);
    idle(1);
    send({8'd20, 8'd5, 8'd6, 8'd1, 8'd2, 8'd3}, 8'd200, 1'b1,
         {24'hFFFFFF, 24'h000000}, 1'b0, 1'b1);
    idle(3);
    send({8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0}, 8'd200, 1'b0,
         {24'hFFFFFF, 24'h000000}, 1'b1, 1'b1);
    idle(2);
    // new frame: T=200 -> lim 600
    send({8'd200, 8'd200, 8'd201, 8'd200, 8'd200, 8'd200}, 8'd200, 1'b0,
         {24'hFFFFFF, 24'h000000}, 1'b0, 1'b1);
    idle(4);

    // 5: 8 back-to-back pairs, to-zero T=50 (lim 150), sum = 150+i
    do_reset(2);
    threshold_Value = 8'd50;
    threshold_Mode  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [47:0] d;
      exp_t e;
      d = {8'(50 + i), 8'd50, 8'd50, 8'd100, 8'd30, 8'(20 + i)};
      set_pair(1'b1, d);
      e.cyc  = cyc + 2;
      e.dat  = (i > 0) ? d : 48'h0;
      e.done = (i == 3) || (i == 7);
      sb.push_back(e);
      tick();
    end
    idle(4);

    // 6: reset one cycle after the 3rd pair (lim 180)
    do_reset(2);
    send({8'd61, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60}, 8'd60, 1'b0,
         {24'hFFFFFF, 24'h000000}, 1'b0, 1'b1);
    idle(1);
    send({8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0}, 8'd60, 1'b0,
         {24'h000000, 24'hFFFFFF}, 1'b0, 1'b1);
    idle(1);
    send({8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200}, 8'd60, 1'b0,
         48'h0, 1'b0, 1'b0);
    do_reset(2);
    // restart: T=20 -> lim 60, captured here only
    send({8'd20, 8'd20, 8'd21, 8'd20, 8'd20, 8'd20}, 8'd20, 1'b0,
         {24'hFFFFFF, 24'h000000}, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      send({8'd30, 8'd30, 8'd1, 8'd0, 8'd0, 8'd0}, 8'd250, 1'b1,
           {24'hFFFFFF, 24'h000000}, (i == 2), 1'b1);
    idle(5);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected pairs never emitted, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
